// File: rtl/hyp_128b_sched.sv
// Round-robin scheduler sharing one combinational hyp_128b datapath between NREQ requesters.
// Operands are registered into the datapath and the result is captured after SETTLE cycles.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request; grant by round-robin from last+1
// WAIT  | operands held on hyp_in0/hyp_in1 while the datapath settles
// RESP  | result held on rsp_data, rsp_valid to owner until rsp_ready
module hyp_128b_sched #(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 128,
  parameter int SETTLE = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]         rsp_valid,
  input  logic [NREQ-1:0]         rsp_ready,
  output logic [WIDTH-1:0]        rsp_data,
  output logic [WIDTH-1:0]        hyp_in0,
  output logic [WIDTH-1:0]        hyp_in1,
  input  logic [WIDTH-1:0]        hyp_out0,
  output logic                    busy
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  last;
  logic [IDX_W-1:0]  owner;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_any;

  // First valid requester searching upward from last+1 with wrap.
  always_comb begin
    int               j;
    logic [IDX_W-1:0] cand;
    grant_any = 1'b0;
    grant_idx = '0;
    j         = 0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      j    = (int'(last) + k) % NREQ;
      cand = IDX_W'(j);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_any) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= IDX_W'(NREQ - 1);
      owner     <= '0;
      cnt       <= '0;
      hyp_in0   <= '0;
      hyp_in1   <= '0;
      rsp_data  <= '0;
      rsp_valid <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            hyp_in0 <= req_a[int'(grant_idx)*WIDTH +: WIDTH];
            hyp_in1 <= req_b[int'(grant_idx)*WIDTH +: WIDTH];
            owner   <= grant_idx;
            last    <= grant_idx;
            cnt     <= CNT_W'(SETTLE);
            busy    <= 1'b1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          // Datapath is a multicycle path: only sample it once the budget expires.
          if (cnt == CNT_W'(1)) begin
            rsp_data  <= hyp_out0;
            rsp_valid <= NREQ'(1) << owner;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready[owner]) begin
            rsp_valid <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hyp_128b_sched.sv
// Bench for hyp_128b_sched: emulates the hyp_128b datapath, keeps a transaction-level
// reference model checked every cycle, plus a vector table and directed corner sequences.
module tb_hyp_128b_sched;
  localparam int NREQ   = 4;
  localparam int W      = 128;
  localparam int SETTLE = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*W-1:0]   req_a;
  logic [NREQ*W-1:0]   req_b;
  logic [NREQ-1:0]     rsp_valid;
  logic [NREQ-1:0]     rsp_ready;
  logic [W-1:0]        rsp_data;
  logic [W-1:0]        hyp_in0;
  logic [W-1:0]        hyp_in1;
  logic [W-1:0]        hyp_out0;
  logic                busy;

  always #5 clk = ~clk;

  // floor(sqrt(x^2 + y^2)) by bitwise search
  function automatic logic [W-1:0] hyp(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W+1:0] xx, yy, s, t;
    logic [W-1:0]   r;
    xx = {{(W+2){1'b0}}, x};
    yy = {{(W+2){1'b0}}, y};
    s  = xx * xx + yy * yy;
    r  = '0;
    for (int i = W - 1; i >= 0; i--) begin
      t    = {{(W+2){1'b0}}, r};
      t[i] = 1'b1;
      if (t * t <= s) r[i] = 1'b1;
    end
    return r;
  endfunction

  assign hyp_out0 = hyp(hyp_in0, hyp_in1);

  hyp_128b_sched #(.NREQ(NREQ), .WIDTH(W), .SETTLE(SETTLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .hyp_in0   (hyp_in0),
    .hyp_in1   (hyp_in1),
    .hyp_out0  (hyp_out0),
    .busy      (busy)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: one transaction in flight, round-robin pointer, capture time stamp.
  bit           m_en   = 1'b0;
  bit           m_busy = 1'b0;
  int           m_owner = 0;
  int           m_last  = NREQ - 1;
  int           m_cap   = 0;
  logic [W-1:0] m_in0 = '0, m_in1 = '0, m_data = '0, m_prev = '0;

  logic [NREQ-1:0] s_ready, s_rv;
  logic [W-1:0]    s_data;
  logic            s_busy;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  // One clock: sample at negedge, check against model, advance model, return at posedge+1.
  task automatic cycle();
    int              g;
    bit              resp;
    logic [NREQ-1:0] er, ev;
    @(negedge clk);
    s_ready = req_ready;
    s_rv    = rsp_valid;
    s_data  = rsp_data;
    s_busy  = busy;
    resp = m_busy && (cyc >= m_cap);
    g    = m_busy ? -1 : rr_pick(req_valid, m_last);
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    ev = '0;
    if (resp) ev[m_owner] = 1'b1;
    if (m_en) begin
      chk("model_req_ready", req_ready, er);
      chk("model_rsp_valid", rsp_valid, ev);
      chk("model_rsp_data", rsp_data, resp ? m_data : m_prev);
      chk("model_hyp_in0", hyp_in0, m_in0);
      chk("model_hyp_in1", hyp_in1, m_in1);
      chk("model_busy", busy, m_busy);
    end
    if (!rst_n) begin
      m_en = 1'b1; m_busy = 1'b0; m_last = NREQ - 1; m_owner = 0;
      m_in0 = '0; m_in1 = '0; m_prev = '0;
    end else if (g >= 0) begin
      m_busy  = 1'b1;
      m_owner = g;
      m_last  = g;
      m_in0   = req_a[g*W +: W];
      m_in1   = req_b[g*W +: W];
      m_data  = hyp(m_in0, m_in1);
      // capture edge is SETTLE edges after the accept edge; visible at the following negedge
      m_cap   = cyc + SETTLE + 1;
    end else if (resp && rsp_ready[m_owner]) begin
      m_busy = 1'b0;
      m_prev = m_data;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin cycle(); n++; end while (s_rv == '0 && n < 100);
  endtask

  task automatic txn(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] exp, input string tag);
    int              n;
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[i] = 1'b1;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_valid[i] = 1'b1;
    rsp_ready = '1;
    n = 0;
    do begin cycle(); n++; end while (!s_ready[i] && n < 100);
    chk({tag, "_grant"}, s_ready, oh);
    req_valid[i] = 1'b0;
    wait_rsp(n);
    chk({tag, "_latency"}, n, SETTLE + 1);
    chk({tag, "_rsp_valid"}, s_rv, oh);
    chk({tag, "_rsp_data"}, s_data, exp);
    cycle();
    chk({tag, "_busy_after"}, s_busy, 1'b0);
  endtask

  typedef struct {
    int           idx;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n, na, nr, t, r3, v3, v0, bad;
    int ord[5], acc[5], rsp[5];
    logic [W-1:0] big;

    vecs[0] = '{0, 128'd3, 128'd4, 128'd5};
    vecs[1] = '{1, 128'd6, 128'd8, 128'd10};
    vecs[2] = '{2, 128'd5, 128'd12, 128'd13};
    vecs[3] = '{3, 128'd8, 128'd15, 128'd17};
    vecs[4] = '{0, 128'd20, 128'd21, 128'd29};
    vecs[5] = '{1, 128'd0, 128'd0, 128'd0};
    vecs[6] = '{2, 128'd1, 128'd1, 128'd1};
    vecs[7] = '{3, 128'd7, 128'd24, 128'd25};
    big = 128'h1_0000_0000_0000_0000;

    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '0;

    do_reset();
    chk("reset_req_ready", s_ready, 4'b0000);
    chk("reset_rsp_valid", s_rv, 4'b0000);
    chk("reset_rsp_data", s_data, 128'd0);
    chk("reset_busy", s_busy, 1'b0);
    chk("reset_hyp_in0", hyp_in0, 128'd0);

    for (int v = 0; v < 8; v++) txn(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].exp, "vec");

    // simultaneous requests 0 and 2 straight after reset
    do_reset();
    req_a[0*W +: W] = 128'd5; req_b[0*W +: W] = 128'd12;
    req_a[2*W +: W] = 128'd8; req_b[2*W +: W] = 128'd15;
    req_valid = 4'b0101;
    rsp_ready = '1;
    cycle();
    chk("simul_first_grant", s_ready, 4'b0001);
    req_valid[0] = 1'b0;
    wait_rsp(n);
    chk("simul_rsp0_valid", s_rv, 4'b0001);
    chk("simul_rsp0_data", s_data, 128'd13);
    n = 0;
    do begin cycle(); n++; end while (s_ready == '0 && n < 100);
    chk("simul_second_grant", s_ready, 4'b0100);
    req_valid[2] = 1'b0;
    wait_rsp(n);
    chk("simul_rsp2_valid", s_rv, 4'b0100);
    chk("simul_rsp2_data", s_data, 128'd17);
    cycle();

    // all requesters continuously valid
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = W'(i + 3);
      req_b[i*W +: W] = W'(i + 4);
    end
    req_valid = '1;
    rsp_ready = '1;
    na = 0; nr = 0; t = 0;
    while (na < 5 && t < 300) begin
      cycle();
      t++;
      if (s_ready != '0) begin
        for (int j = 0; j < NREQ; j++) if (s_ready[j]) ord[na] = j;
        acc[na] = t;
        na++;
      end
      if (s_rv != '0 && nr < 5) begin
        rsp[nr] = t;
        nr++;
      end
    end
    req_valid = '0;
    chk("rr_accept_count", na, 5);
    for (int k = 0; k < 5; k++) chk("rr_order", ord[k], k % NREQ);
    for (int k = 0; k < 4; k++) chk("rr_spacing", acc[k+1] - acc[k], SETTLE + 2);
    for (int k = 0; k < 4; k++) chk("rr_rsp_delay", rsp[k] - acc[k], SETTLE + 1);
    for (int k = 0; k < 12; k++) cycle();

    // response stall by owner 1, non-owner rsp_ready high
    req_a[1*W +: W] = big;
    req_b[1*W +: W] = '0;
    req_valid[1] = 1'b1;
    rsp_ready = 4'b0001;
    n = 0;
    do begin cycle(); n++; end while (!s_ready[1] && n < 100);
    chk("stall_grant", s_ready, 4'b0010);
    req_valid[1] = 1'b0;
    wait_rsp(n);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (s_rv !== 4'b0010 || s_data !== big) bad++;
      cycle();
    end
    chk("stall_held_cycles_bad", bad, 0);
    chk("stall_rsp_data", s_data, big);
    rsp_ready = 4'b0011;
    cycle();
    chk("stall_rsp_valid_at_release", s_rv, 4'b0010);
    cycle();
    chk("stall_idle_after_release", s_busy, 1'b0);
    chk("stall_rsp_valid_cleared", s_rv, 4'b0000);

    // reset pulse in the middle of WAIT
    req_a[0*W +: W] = 128'd3; req_b[0*W +: W] = 128'd4;
    req_valid[0] = 1'b1;
    rsp_ready = '1;
    n = 0;
    do begin cycle(); n++; end while (!s_ready[0] && n < 100);
    req_valid[0] = 1'b0;
    for (int k = 0; k < 4; k++) cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    chk("abort_busy", s_busy, 1'b0);
    chk("abort_rsp_valid", s_rv, 4'b0000);
    chk("abort_rsp_data", s_data, 128'd0);
    chk("abort_hyp_in0", hyp_in0, 128'd0);
    chk("abort_hyp_in1", hyp_in1, 128'd0);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (s_rv != '0) bad++;
    end
    chk("abort_no_response", bad, 0);
    txn(0, 128'd6, 128'd8, 128'd10, "after_abort");

    // requester 3 withdraws before grant while 0 is in WAIT
    req_a[0*W +: W] = 128'd9; req_b[0*W +: W] = 128'd12;
    req_valid[0] = 1'b1;
    rsp_ready = '1;
    n = 0;
    do begin cycle(); n++; end while (!s_ready[0] && n < 100);
    req_valid[0] = 1'b0;
    r3 = 0; v3 = 0; v0 = 0;
    for (int k = 0; k < 30; k++) begin
      if (k == 2) begin
        req_a[3*W +: W] = 128'd11; req_b[3*W +: W] = 128'd60;
        req_valid[3] = 1'b1;
      end
      if (k == 5) req_valid[3] = 1'b0;
      cycle();
      if (s_ready[3]) r3++;
      if (s_rv[3]) v3++;
      if (s_rv[0]) begin
        v0++;
        chk("drop_rsp0_data", s_data, 128'd15);
      end
    end
    chk("drop_req3_granted", r3, 0);
    chk("drop_req3_rsp", v3, 0);
    chk("drop_req0_rsp_count", v0, 1);

    // random traffic against the model
    for (int k = 0; k < 600; k++) begin
      req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          req_a[i*W +: W] = {64'd0, $urandom, $urandom};
          req_b[i*W +: W] = {64'd0, $urandom, $urandom};
        end
      end
      rsp_ready = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      rst_n = ($urandom_range(0, 149) != 0);
      cycle();
    end
    rst_n = 1'b1;
    req_valid = '0;
    rsp_ready = '1;
    for (int k = 0; k < 15; k++) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hyp_128b_sched.md
# hyp_128b_sched

Round-robin scheduler that shares one combinational `hyp_128b` datapath instance (out0 = hypotenuse of in0, in1) between `NREQ` requesters. It grants one request at a time and drives registered operands into the datapath. It waits a fixed number of settle cycles, because the datapath is timed as a multicycle path. It then captures the result and returns it to the owning requester over a valid/ready response channel. It sits between client blocks and the single `hyp_128b` instance at the top level.

## Interface
- `NREQ`, 4: number of requesters (2..16).
- `WIDTH`, 128: operand/result width; must match the datapath.
- `SETTLE`, 8: clock cycles allowed for the datapath to settle (>= 1).
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in NREQ: per-requester operand valid.
- `req_ready` out NREQ: per-requester accept, one-hot or zero.
- `req_a` in NREQ*WIDTH: operand A; requester i uses bits [i*WIDTH +: WIDTH].
- `req_b` in NREQ*WIDTH: operand B; same packing.
- `rsp_valid` out NREQ: result valid, one-hot to the owner, or zero.
- `rsp_ready` in NREQ: per-requester result accept.
- `rsp_data` out WIDTH: result, shared by all requesters.
- `hyp_in0` out WIDTH: registered operand to datapath in0.
- `hyp_in1` out WIDTH: registered operand to datapath in1.
- `hyp_out0` in WIDTH: datapath out0.
- `busy` out 1: high in every state except IDLE.

## Operation
- States are IDLE, WAIT and RESP.
- IDLE:
  - Grant goes to the first requester with `req_valid` high, searching from `last+1` mod NREQ upward with wrap.
  - `req_ready[g]` = 1 combinationally for that requester only.
  - On the edge with valid&ready:
    - `req_a[g]` goes to `hyp_in0` and `req_b[g]` to `hyp_in1`.
    - `owner` = g and `last` = g.
    - The counter loads SETTLE and the state goes to WAIT.
- WAIT:
  - The counter decrements each edge.
  - On the edge where the counter equals 1, `hyp_out0` is captured into `rsp_data` and the state goes to RESP.
  - `hyp_in0`/`hyp_in1` are held constant throughout WAIT.
- RESP:
  - `rsp_valid[owner]` = 1.
  - On the edge where `rsp_ready[owner]` = 1, the state returns to IDLE.
  - `rsp_ready` of non-owners is ignored.
- `hyp_in0`/`hyp_in1`/`rsp_data` hold their last values outside capture edges.
- No arithmetic is performed in this block. Widths are passed through unchanged, and the datapath owns overflow behaviour.
- A requester must hold `req_valid` and operands until it sees `req_ready`. Dropping `req_valid` before grant is legal, and that requester is simply skipped.
- Reset values:
  - state IDLE.
  - `last` = NREQ-1, so requester 0 has first priority.
  - `owner` = 0, counter 0.
  - `hyp_in0` = `hyp_in1` = `rsp_data` = 0.
  - `req_ready` = `rsp_valid` = 0, `busy` = 0.
- Reset asserted in WAIT or RESP aborts the transaction. No response is issued, and the pending result is lost.

## Timing
- Accept edge E0 → result captured at edge E0+SETTLE → `rsp_valid` high from E0+SETTLE until the response handshake edge.
- The earliest next accept is one edge after the response handshake, because IDLE lasts at least one cycle.
- Peak throughput is one operation per SETTLE+2 cycles.
- `req_ready` is combinational from `req_valid` and state only. There is no combinational path from `hyp_out0` to any output.
- Simultaneous requests: exactly one `req_ready` is asserted, and the others wait.
- A request arriving during WAIT or RESP is not accepted until IDLE.
- Rotation wraps at NREQ-1 → 0.
- `rsp_ready` held low stalls RESP indefinitely. `rsp_data` and `rsp_valid` are held stable during the stall.

## Test plan
- Reset, then requester 0 sends a=3, b=4 with SETTLE=8 → `req_ready[0]` in the same cycle. `hyp_in0`=3 and `hyp_in1`=4 after E0. `rsp_valid`=4'b0001 with `rsp_data`=5 from E0+8. `busy` falls after the response handshake.
- Requesters 0 and 2 both valid from reset, with (5,12) and (8,15) → 0 is served first and returns 13. Requester 2 is served next and returns 17 on `rsp_valid`=4'b0100.
- All four requesters held valid continuously → grant order 0,1,2,3,0. Each response appears SETTLE cycles after its accept, and accepts are spaced SETTLE+2 cycles apart with `rsp_ready` tied high.
- Owner 1 holds `rsp_ready` low for 20 cycles with (2^64, 0) → `rsp_data`=2^64 stable throughout. `rsp_ready[0]`=1 meanwhile has no effect. IDLE is entered one edge after `rsp_ready[1]` rises.
- `rst_n` low for one edge midway through WAIT → all outputs return to reset values. No `rsp_valid` is ever raised for the aborted operation. The next request (6,8) returns 10 normally.
- Requester 3 raises `req_valid` then drops it before grant while requester 0 is in WAIT → requester 3 is never granted and no response is issued to it.
